// File: rtl/row_feeder_if.sv
// row_feeder_if: tracer-to-renderer wall-data handshake with VGA position and status
interface row_feeder_if;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        in_valid;
    logic        in_ready;
    logic        in_side;
    logic [10:0] in_size;
    logic        out_side;
    logic [10:0] out_size;
    logic [9:0]  next_line;
    logic        underrun;
    logic [7:0]  underrun_count;
    modport master (
        output hpos, vpos, in_valid, in_side, in_size,
        input  in_ready, out_side, out_size, next_line, underrun, underrun_count
    );
    modport slave (
        input  hpos, vpos, in_valid, in_side, in_size,
        output in_ready, out_side, out_size, next_line, underrun, underrun_count
    );
endinterface

// File: rtl/row_feeder.sv
// row_feeder: one-slot buffer that swaps tracer wall data into the live renderer registers at hblank
module row_feeder #(
    parameter int H_SWAP  = 640,
    parameter int V_LINES = 480,
    parameter int V_TOTAL = 525
) (
    input logic clk,
    input logic reset,
    row_feeder_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t      state;
    logic        p_side;
    logic [10:0] p_size;
    logic        swap;
    logic        xfer;
    assign bus.next_line = (bus.vpos == 10'(V_TOTAL - 1)) ? 10'd0 : bus.vpos + 10'd1;
    assign bus.in_ready  = (state == EMPTY) && reset;
    assign swap = (bus.hpos == 10'(H_SWAP)) && (bus.next_line < 10'(V_LINES));
    assign xfer = bus.in_valid && bus.in_ready;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= EMPTY;
            p_side             <= 1'b0;
            p_size             <= 11'd0;
            bus.out_side       <= 1'b0;
            bus.out_size       <= 11'd0;
            bus.underrun       <= 1'b0;
            bus.underrun_count <= 8'd0;
        end else begin
            bus.underrun <= swap && (state == EMPTY) && !xfer;
            if (swap) begin
                if (state == FULL) begin
                    bus.out_side <= p_side;
                    bus.out_size <= p_size;
                    state        <= EMPTY;
                end else if (xfer) begin
                    bus.out_side <= bus.in_side;
                    bus.out_size <= bus.in_size;
                end else begin
                    bus.out_side       <= 1'b0;
                    bus.out_size       <= 11'd0;
                    bus.underrun_count <= bus.underrun_count + 8'(bus.underrun_count != 8'hff);
                end
            end else if (xfer) begin
                p_side <= bus.in_side;
                p_size <= bus.in_size;
                state  <= FULL;
            end
        end
    end
endmodule

// File: tb/tb_row_feeder.sv
// tb_row_feeder: directed self-checking bench for row_feeder
module tb_row_feeder;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    row_feeder_if bus();
    row_feeder dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic walk_to(input logic [9:0] h);
        while (bus.hpos != h) begin
            tick();
            bus.hpos = bus.hpos + 10'd1;
        end
        #1;
    endtask
    task automatic swap_edge();
        bus.hpos = 10'd640;
        tick();
        bus.hpos = 10'd641;
        #1;
    endtask
    initial begin
        reset = 1'b0;
        bus.hpos = 10'd0;
        bus.vpos = 10'd10;
        bus.in_valid = 1'b0;
        bus.in_side = 1'b0;
        bus.in_size = 11'd0;
        repeat (3) tick();
        chk("rst_ready_low", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.in_ready), 32'd1);
        chk("rel_size", 32'(bus.out_size), 32'd0);
        chk("rel_side", 32'(bus.out_side), 32'd0);
        chk("rel_count", 32'(bus.underrun_count), 32'd0);
        chk("rel_next_line", 32'(bus.next_line), 32'd11);
        bus.hpos = 10'd100;
        bus.in_valid = 1'b1;
        bus.in_side = 1'b1;
        bus.in_size = 11'd200;
        tick();
        bus.in_valid = 1'b0;
        bus.hpos = 10'd101;
        #1;
        chk("push_ready_low", 32'(bus.in_ready), 32'd0);
        walk_to(10'd640);
        chk("pre_swap_size", 32'(bus.out_size), 32'd0);
        tick();
        bus.hpos = 10'd641;
        #1;
        chk("swap_size", 32'(bus.out_size), 32'd200);
        chk("swap_side", 32'(bus.out_side), 32'd1);
        chk("swap_ready", 32'(bus.in_ready), 32'd1);
        chk("swap_no_underrun", 32'(bus.underrun), 32'd0);
        bus.hpos = 10'd0;
        walk_to(10'd640);
        tick();
        bus.hpos = 10'd641;
        #1;
        chk("ur_pulse", 32'(bus.underrun), 32'd1);
        chk("ur_size", 32'(bus.out_size), 32'd0);
        chk("ur_side", 32'(bus.out_side), 32'd0);
        chk("ur_count", 32'(bus.underrun_count), 32'd1);
        tick();
        chk("ur_pulse_end", 32'(bus.underrun), 32'd0);
        bus.hpos = 10'd640;
        bus.in_valid = 1'b1;
        bus.in_side = 1'b0;
        bus.in_size = 11'd37;
        #1;
        chk("direct_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.hpos = 10'd641;
        #1;
        chk("direct_size", 32'(bus.out_size), 32'd37);
        chk("direct_side", 32'(bus.out_side), 32'd0);
        chk("direct_no_ur", 32'(bus.underrun), 32'd0);
        chk("direct_count", 32'(bus.underrun_count), 32'd1);
        chk("direct_empty", 32'(bus.in_ready), 32'd1);
        bus.vpos = 10'd479;
        #1;
        chk("nl_480", 32'(bus.next_line), 32'd480);
        swap_edge();
        chk("vblank479_no_ur", 32'(bus.underrun), 32'd0);
        chk("vblank479_size", 32'(bus.out_size), 32'd37);
        bus.vpos = 10'd500;
        bus.hpos = 10'd100;
        bus.in_valid = 1'b1;
        bus.in_side = 1'b1;
        bus.in_size = 11'd99;
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("v500_next_line", 32'(bus.next_line), 32'd501);
        chk("v500_full", 32'(bus.in_ready), 32'd0);
        swap_edge();
        chk("v500_no_swap", 32'(bus.out_size), 32'd37);
        chk("v500_still_full", 32'(bus.in_ready), 32'd0);
        chk("v500_no_ur", 32'(bus.underrun), 32'd0);
        bus.vpos = 10'd524;
        #1;
        chk("v524_next_line", 32'(bus.next_line), 32'd0);
        swap_edge();
        chk("v524_size", 32'(bus.out_size), 32'd99);
        chk("v524_side", 32'(bus.out_side), 32'd1);
        chk("v524_ready", 32'(bus.in_ready), 32'd1);
        chk("v524_count", 32'(bus.underrun_count), 32'd1);
        bus.vpos = 10'd10;
        repeat (253) begin
            swap_edge();
            tick();
        end
        chk("sat_254", 32'(bus.underrun_count), 32'd254);
        swap_edge();
        chk("sat_255", 32'(bus.underrun_count), 32'd255);
        repeat (46) begin
            swap_edge();
            tick();
        end
        chk("sat_hold", 32'(bus.underrun_count), 32'd255);
        bus.hpos = 10'd100;
        bus.in_valid = 1'b1;
        bus.in_side = 1'b1;
        bus.in_size = 11'd5;
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("mid_full", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_rst_count", 32'(bus.underrun_count), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(bus.in_ready), 32'd1);
        swap_edge();
        chk("mid_ur", 32'(bus.underrun), 32'd1);
        chk("mid_ur_size", 32'(bus.out_size), 32'd0);
        chk("mid_ur_count", 32'(bus.underrun_count), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/row_feeder.md
ROW_FEEDER -- requirements
Module: row_feeder

Interface
REQ-001 Parameter H_SWAP, default 640: hpos value (first horizontal-blank pixel) at which the next line's wall data becomes live.
REQ-002 Parameter V_LINES, default 480: number of visible lines.
REQ-003 Parameter V_TOTAL, default 525: total lines per frame, including vertical blanking.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (low = reset asserted), sampled on rising clk.
REQ-006 hpos  input  10  current horizontal pixel position from the VGA sync driver.
REQ-007 vpos  input  10  current line from the VGA sync driver.
REQ-008 in_valid  input  1  tracer presents wall data for line next_line.
REQ-009 in_ready  output  1  block can accept in_side/in_size this cycle.
REQ-010 in_side  input  1  wall side flag (shading select) from the tracer.
REQ-011 in_size  input  11  wall height from the tracer.
REQ-012 out_side  output  1  live side flag; drives the row renderer's side input.
REQ-013 out_size  output  11  live wall height; drives the row renderer's size input.
REQ-014 next_line  output  10  index of the line whose data the tracer must supply next.
REQ-015 underrun  output  1  one-cycle pulse: a swap found no data.
REQ-016 underrun_count  output  8  saturating count of underruns since reset.

Function
REQ-017 Storage: one pending slot {side,size,full} and one live register {out_side,out_size}, all registered.
REQ-018 Pending FSM has two states: EMPTY and FULL; in_ready SHALL equal (state==EMPTY) and reset deasserted.
REQ-019 Handshake: a transfer occurs on a cycle with in_valid && in_ready; the block SHALL capture in_side/in_size and move EMPTY->FULL.
REQ-020 While FULL, in_ready is 0; in_* values SHALL be ignored and the tracer must hold them.
REQ-021 next_line = vpos+1, except next_line = 0 when vpos == V_TOTAL-1; combinational from vpos.
REQ-022 Swap cycle: hpos == H_SWAP && next_line < V_LINES; at most one per line; no swaps for lines feeding vertical blanking.
REQ-023 On a swap cycle with state FULL: live <= pending, state -> EMPTY; new out_* visible on the following cycle.
REQ-024 On a swap cycle with state EMPTY and a transfer in the same cycle: the accepted data SHALL load directly into live, state stays EMPTY, no underrun.
REQ-025 On a swap cycle with state EMPTY and no transfer: live <= {0,0} (no wall), underrun pulses high for exactly the next cycle, underrun_count increments.
REQ-026 underrun_count saturates at 255 and never wraps.
REQ-027 Outside swap cycles, live registers hold their value.
REQ-028 hpos/vpos values at or beyond H_SWAP/V_TOTAL other than the defined compare points SHALL have no effect.

Reset
REQ-029 While reset is low, on each rising clk: state=EMPTY, out_side=0, out_size=0, underrun=0, underrun_count=0; in_ready=0.
REQ-030 Reset asserted mid-line discards pending data; first swap after release follows REQ-023..025 normally.
REQ-031 No transfer, swap or count update occurs on a cycle where reset is low.

Verification
REQ-032 Reset low 3 cycles, release -> out_size=0, out_side=0, underrun_count=0, in_ready=1 on first cycle after release.
REQ-033 vpos=10, push {1,200} at hpos=100, tick to hpos=640 -> in_ready=0 from hpos=101, out={1,200} at hpos=641, in_ready=1 again.
REQ-034 vpos=10, no push, hpos reaches 640 -> out_size=0, underrun=1 for one cycle, underrun_count=1.
REQ-035 vpos=10, in_valid with {0,37} exactly at hpos=640, state EMPTY -> out={0,37} next cycle, underrun stays 0.
REQ-036 vpos=500 and vpos=524 at hpos=640 with pending FULL -> no swap at 500 (out unchanged, state FULL); swap at 524 (next_line=0).
REQ-037 Force 300 underruns -> underrun_count holds 255; reset low mid-line with pending FULL -> pending dropped, count=0.
